// File: rtl/kmeans_pkg.sv
// Shared K-means definitions: cluster count, index width and the centroid-load FSM states.
package kmeans_pkg;

    localparam int MAX_K = 8;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] IDX_NONE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // A load needs at least one centroid and at most one per cluster unit.
    function automatic logic k_legal(input logic [IDX_W-1:0] k);
        return (k != IDX_NONE) && (k <= IDX_W'(MAX_K));
    endfunction

endpackage

// File: rtl/centroid_load_ctrl.sv
// Loads the first K centroid words into cluster units 1..K through the demux,
// one word per accepted handshake, and reports completion or a bad K.
module centroid_load_ctrl
    import kmeans_pkg::*;
#(
    parameter int DATA_W = 91
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  k_cfg,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] demux_data,
    output logic [IDX_W-1:0]  demux_index,
    output logic [IDX_W-1:0]  loaded_cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    // Handshake: a word moves when in_valid && in_ready at a rising edge;
    // in_ready is high only while loading, and an abort in the same cycle cancels it.

    load_state_t       state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  loaded_cnt_q, loaded_cnt_d;
    logic [DATA_W-1:0] demux_data_q, demux_data_d;
    logic [IDX_W-1:0]  demux_index_q, demux_index_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              xfer;
    logic              last_word;
    logic [IDX_W-1:0]  cnt_inc;

    assign xfer      = (state_q == LOAD) && in_valid && !abort;
    assign cnt_inc   = loaded_cnt_q + IDX_W'(1);
    assign last_word = (cnt_inc == k_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            loaded_cnt_q  <= '0;
            demux_data_q  <= '0;
            demux_index_q <= IDX_NONE;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            loaded_cnt_q  <= loaded_cnt_d;
            demux_data_q  <= demux_data_d;
            demux_index_q <= demux_index_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && k_legal(k_cfg)) state_d = LOAD;
            LOAD: begin
                if (abort)                  state_d = IDLE;
                else if (xfer && last_word) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        k_d           = k_q;
        loaded_cnt_d  = loaded_cnt_q;
        demux_data_d  = demux_data_q;
        demux_index_d = IDX_NONE;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_legal(k_cfg)) begin
                        k_d          = k_cfg;
                        loaded_cnt_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    demux_data_d  = in_data;
                    demux_index_d = cnt_inc;
                    loaded_cnt_d  = cnt_inc;
                    done_d        = last_word;
                end
            end
            default: ;
        endcase
        busy_d     = (state_d == LOAD);
        in_ready_d = (state_d == LOAD);
    end

    assign in_ready    = in_ready_q;
    assign demux_data  = demux_data_q;
    assign demux_index = demux_index_q;
    assign loaded_cnt  = loaded_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_centroid_load_ctrl.sv
// Bench for centroid_load_ctrl: a hand-written vector table, directed corner
// sequences and random traffic, all checked against a behavioural model.
module tb_centroid_load_ctrl;

    localparam int DW = 91;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    k_cfg;
    logic          abort;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] demux_data;
    logic [3:0]    demux_index;
    logic [3:0]    loaded_cnt;
    logic          busy;
    logic          done;
    logic          cfg_err;

    centroid_load_ctrl #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_cfg       (k_cfg),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .demux_data  (demux_data),
        .demux_index (demux_index),
        .loaded_cnt  (loaded_cnt),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    int idx_seen[16];
    logic [DW+3:0] exp_q[$];

    // ---------------- reference model ----------------
    // phase: 0 = idle, 1 = collecting words, 2 = completion cycle
    int            m_phase = 0;
    int            m_k = 0;
    int            m_cnt = 0;
    logic [3:0]    e_idx = '0;
    logic [DW-1:0] e_data = '0;
    logic          e_busy = 1'b0;
    logic          e_done = 1'b0;
    logic          e_err = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic s, input logic [3:0] k,
                                input logic a, input logic v, input logic [DW-1:0] d);
        e_idx  = '0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!r) begin
            m_phase = 0;
            m_k     = 0;
            m_cnt   = 0;
            e_data  = '0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (s) begin
                        if (int'(k) >= 1 && int'(k) <= 8) begin
                            m_phase = 1;
                            m_k     = int'(k);
                            m_cnt   = 0;
                        end else begin
                            e_err = 1'b1;
                        end
                    end
                end
                1: begin
                    if (a) begin
                        m_phase = 0;
                    end else if (v) begin
                        m_cnt  = m_cnt + 1;
                        e_idx  = 4'(m_cnt);
                        e_data = d;
                        exp_q.push_back({4'(m_cnt), d});
                        if (m_cnt == m_k) begin
                            m_phase = 2;
                            e_done  = 1'b1;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
        e_busy = (m_phase == 1);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic s, input logic [3:0] k,
                        input logic a, input logic v, input logic [DW-1:0] d);
        logic [DW+3:0] sb;
        rst_n    = r;
        start    = s;
        k_cfg    = k;
        abort    = a;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_update(r, s, k, a, v, d);
        #1;
        check("in_ready",    128'(in_ready),    128'(e_busy));
        check("busy",        128'(busy),        128'(e_busy));
        check("done",        128'(done),        128'(e_done));
        check("cfg_err",     128'(cfg_err),     128'(e_err));
        check("demux_index", 128'(demux_index), 128'(e_idx));
        check("demux_data",  128'(demux_data),  128'(e_data));
        check("loaded_cnt",  128'(loaded_cnt),  128'(m_cnt));
        if (demux_index != 4'd0) begin
            idx_seen[demux_index]++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 128'(demux_index), 128'(0));
            end else begin
                sb = exp_q.pop_front();
                check("sb_word", 128'({demux_index, demux_data}), 128'(sb));
            end
        end
        check("sb_pending", 128'(exp_q.size()), 128'(0));
        if (done) done_seen++;
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic clear_seen();
        done_seen = 0;
        for (int i = 0; i < 16; i++) idx_seen[i] = 0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst_n;
        logic          start;
        logic [3:0]    k_cfg;
        logic          abort;
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic [3:0]    e_idx;
        logic [DW-1:0] e_data;
        logic [3:0]    e_cnt;
        logic          e_busy;
        logic          e_done;
        logic          e_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [DW-1:0] wa, wb, wc, w;
        wa = {27'h5a5a5a5, 64'hA0A0_A0A0_A0A0_A0A1};
        wb = {27'h1234567, 64'hB0B0_B0B0_B0B0_B0B2};
        wc = {27'h7ffffff, 64'hC0C0_C0C0_C0C0_C0C3};

        //          rst start k     abort val data  idx   data  cnt   busy done err
        tbl[0] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0, 4'd0, '0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, '0, 4'd0, '0, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, wa, 4'd1, wa, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, wb, 4'd2, wb, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, wc, 4'd3, wc, 4'd3, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, wa, 4'd0, wc, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, '0, 4'd0, wc, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, wb, 4'd0, wc, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, wb, 4'd0, wc, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 4'd8, 1'b0, 1'b0, '0, 4'd0, wc, 4'd0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; k_cfg = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst_n, tbl[i].start, tbl[i].k_cfg, tbl[i].abort, tbl[i].in_valid, tbl[i].in_data);
            check($sformatf("tbl%0d_idx", i),  128'(demux_index), 128'(tbl[i].e_idx));
            check($sformatf("tbl%0d_data", i), 128'(demux_data),  128'(tbl[i].e_data));
            check($sformatf("tbl%0d_cnt", i),  128'(loaded_cnt),  128'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_busy", i), 128'(busy),        128'(tbl[i].e_busy));
            check($sformatf("tbl%0d_done", i), 128'(done),        128'(tbl[i].e_done));
            check($sformatf("tbl%0d_err", i),  128'(cfg_err),     128'(tbl[i].e_err));
        end
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0);

        // Reset in the middle of a load, then a normal k=2 load.
        clear_seen();
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        check("rst_mid_cnt", 128'(loaded_cnt), 128'(0));
        check("rst_mid_done", 128'(done_seen), 128'(0));
        step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        idle_step();
        check("rst_restart_done", 128'(done_seen), 128'(1));
        check("rst_restart_cnt", 128'(loaded_cnt), 128'(2));

        // Stalled input: k=8 with in_valid alternating.
        clear_seen();
        step(1'b1, 1'b1, 4'd8, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0, (i % 2) == 0, rand_word());
            if (i < 14) check("stall_early_done", 128'(done), 128'(0));
        end
        idle_step();
        for (int i = 1; i <= 8; i++) check($sformatf("stall_idx%0d_once", i), 128'(idx_seen[i]), 128'(1));
        check("stall_done_once", 128'(done_seen), 128'(1));

        // Abort colliding with the third transfer.
        clear_seen();
        step(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, rand_word());
        check("abort_idle_busy", 128'(busy), 128'(0));
        check("abort_idx", 128'(demux_index), 128'(0));
        idle_step();
        check("abort_cnt", 128'(loaded_cnt), 128'(2));
        check("abort_no_done", 128'(done_seen), 128'(0));
        check("abort_no_idx3", 128'(idx_seen[3]), 128'(0));

        // Start while busy is ignored.
        clear_seen();
        step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, rand_word());
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, rand_word());
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, rand_word());
        idle_step();
        check("busy_start_done", 128'(done_seen), 128'(1));
        check("busy_start_cnt", 128'(loaded_cnt), 128'(2));
        check("busy_start_no_idx3", 128'(idx_seen[3]), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            step($urandom_range(0, 149) != 0,
                 $urandom_range(0, 7) == 0,
                 k,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) != 0,
                 rand_word());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
